// File: rtl/match_referee_pkg.sv
// ---------------------------------------------------------------------------
// match_referee_pkg
// Shared types and constants for the tug-of-war match referee.
//   ref_state_t : referee FSM states
//   PW_*        : winner codes driven to the hex display decoder
//   SCORE_W     : width of the per-player score registers
//   win_code()  : maps "player 1 won" to the matching display code
// ---------------------------------------------------------------------------
package match_referee_pkg;

   typedef enum logic [1:0] {
      PLAY    = 2'b00,
      SHOW    = 2'b01,
      RESTART = 2'b10,
      OVER    = 2'b11
   } ref_state_t;

   localparam logic [1:0] PW_NONE = 2'b00;
   localparam logic [1:0] PW_P1   = 2'b01;
   localparam logic [1:0] PW_P2   = 2'b10;

   localparam int SCORE_W = 4;

   function automatic logic [1:0] win_code(input logic p1_took);
      logic [1:0] code;
      if (p1_took) begin
         code = PW_P1;
      end else begin
         code = PW_P2;
      end
      return code;
   endfunction

endpackage

// File: rtl/match_referee_term_counter.sv
// ---------------------------------------------------------------------------
// term_counter
// Terminal counter: counts enabled cycles from 0 up to N-1, then wraps to 0.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-low reset (count -> 0)
//   clr   in  synchronous clear (count -> 0), higher priority than en
//   en    in  count enable
//   done  out high while count == N-1
// ---------------------------------------------------------------------------
module term_counter #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int            W    = $clog2(N) + 1;
   localparam logic [W-1:0]  LAST = W'(N - 1);

   logic [W-1:0] count;

   // Count register with clear and wrap at the terminal value
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + W'(1);
         end
      end else begin
         count <= count;
      end
   end

   assign done = (count == LAST);

endmodule

// File: rtl/match_referee.sv
// ---------------------------------------------------------------------------
// match_referee
// Sequential referee for the two-player tug-of-war game. Latches the round
// winner, shows it for HOLD_CYCLES cycles, pulses round_restart, keeps the
// scores and ends the match when a player reaches WIN_SCORE.
//
// Optional feature macro: MATCH_REFEREE_FLASH_EN
//   defined   -> in OVER, playerWin flashes winner/none every FLASH_HALF cycles
//   undefined -> playerWin is steady in OVER (FLASH_HALF unused)
//
// Ports:
//   clk           in   system clock (rising edge)
//   reset         in   synchronous active-low reset
//   p1_win        in   one-cycle pulse, player 1 took the round
//   p2_win        in   one-cycle pulse, player 2 took the round
//   playerWin     out  winner code: 00 none, 01 P1, 10 P2
//   round_restart out  one-cycle pulse re-centring the playfield
//   p1_score      out  player 1 rounds won
//   p2_score      out  player 2 rounds won
//   match_over    out  high while the match is finished
// All outputs are registered.
// ---------------------------------------------------------------------------
module match_referee import match_referee_pkg::*; #(
   parameter int HOLD_CYCLES = 16,
   parameter int WIN_SCORE   = 3,
   parameter int FLASH_HALF  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               p1_win,
   input  logic               p2_win,
   output logic [1:0]         playerWin,
   output logic               round_restart,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               match_over
);

   // Reject unusable configurations at elaboration time
   if ((HOLD_CYCLES < 1) || (WIN_SCORE < 1) || (WIN_SCORE > 15) || (FLASH_HALF < 1)) begin : g_bad_cfg
      $error("match_referee: parameter out of range");
   end

   localparam logic [SCORE_W-1:0] WIN_TARGET = SCORE_W'(WIN_SCORE);

   ref_state_t         state;
   ref_state_t         state_next;
   logic [1:0]         winner;
   logic [1:0]         winner_next;
   logic [1:0]         pw_next;
   logic               restart_next;
   logic               over_next;
   logic [SCORE_W-1:0] s1_next;
   logic [SCORE_W-1:0] s2_next;
   logic [SCORE_W-1:0] win_score;
   logic               hold_clr;
   logic               hold_en;
   logic               hold_done;

   term_counter #(.N(HOLD_CYCLES)) u_hold (
      .clk   (clk),
      .reset (reset),
      .clr   (hold_clr),
      .en    (hold_en),
      .done  (hold_done)
   );

`ifdef MATCH_REFEREE_FLASH_EN
   logic flash_phase;
   logic flash_phase_next;
   logic flash_done;

   // Flash counter runs only in OVER and restarts on every OVER entry
   term_counter #(.N(FLASH_HALF)) u_flash (
      .clk   (clk),
      .reset (reset),
      .clr   (state != OVER),
      .en    (state == OVER),
      .done  (flash_done)
   );

   // Flash phase register: 0 shows the winner, 1 blanks the display
   always_ff @(posedge clk) begin
      if (!reset) begin
         flash_phase <= 1'b0;
      end else begin
         flash_phase <= flash_phase_next;
      end
   end
`endif

   // Next-state and next-output logic
   always_comb begin
      state_next   = state;
      winner_next  = winner;
      pw_next      = playerWin;
      restart_next = 1'b0;
      over_next    = 1'b0;
      s1_next      = p1_score;
      s2_next      = p2_score;
      hold_clr     = 1'b0;
      hold_en      = 1'b0;
`ifdef MATCH_REFEREE_FLASH_EN
      flash_phase_next = flash_phase;
`endif

      if (winner == PW_P1) begin
         win_score = p1_score;
      end else begin
         win_score = p2_score;
      end

      case (state)
         PLAY: begin
            hold_clr = 1'b1;
            pw_next  = PW_NONE;
            // A simultaneous double pulse is ambiguous and is dropped
            if (p1_win && !p2_win) begin
               state_next  = SHOW;
               winner_next = win_code(1'b1);
               pw_next     = win_code(1'b1);
               s1_next     = p1_score + SCORE_W'(1);
            end else if (p2_win && !p1_win) begin
               state_next  = SHOW;
               winner_next = win_code(1'b0);
               pw_next     = win_code(1'b0);
               s2_next     = p2_score + SCORE_W'(1);
            end else begin
               state_next = PLAY;
            end
         end
         SHOW: begin
            hold_en = 1'b1;
            pw_next = winner;
            if (hold_done) begin
               if (win_score == WIN_TARGET) begin
                  state_next = OVER;
                  over_next  = 1'b1;
`ifdef MATCH_REFEREE_FLASH_EN
                  flash_phase_next = 1'b0;
`endif
               end else begin
                  state_next   = RESTART;
                  restart_next = 1'b1;
                  pw_next      = PW_NONE;
               end
            end else begin
               state_next = SHOW;
            end
         end
         RESTART: begin
            state_next = PLAY;
            pw_next    = PW_NONE;
         end
         OVER: begin
            state_next = OVER;
            over_next  = 1'b1;
`ifdef MATCH_REFEREE_FLASH_EN
            // Phase flips at the end of every FLASH_HALF-cycle window
            flash_phase_next = flash_phase ^ flash_done;
            if (flash_phase_next) begin
               pw_next = PW_NONE;
            end else begin
               pw_next = winner;
            end
`else
            pw_next = winner;
`endif
         end
         default: begin
            state_next = PLAY;
            pw_next    = PW_NONE;
         end
      endcase
   end

   // State and registered output update
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= PLAY;
         winner        <= PW_NONE;
         playerWin     <= PW_NONE;
         round_restart <= 1'b0;
         p1_score      <= '0;
         p2_score      <= '0;
         match_over    <= 1'b0;
      end else begin
         state         <= state_next;
         winner        <= winner_next;
         playerWin     <= pw_next;
         round_restart <= restart_next;
         p1_score      <= s1_next;
         p2_score      <= s2_next;
         match_over    <= over_next;
      end
   end

endmodule

// File: tb/tb_match_referee.sv
// ---------------------------------------------------------------------------
// tb_match_referee
// Self-checking bench for match_referee (HOLD_CYCLES=4, WIN_SCORE=3,
// FLASH_HALF=2). A timeline model derives expected outputs from the edge
// at which the current round was won; directed scenarios are followed by
// a randomized phase.
// ---------------------------------------------------------------------------
module tb_match_referee;

   localparam int HOLD = 4;
   localparam int WIN  = 3;
   localparam int FH   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       p1_win = 1'b0;
   logic       p2_win = 1'b0;
   logic [1:0] playerWin;
   logic       round_restart;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic       match_over;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: edge count, edge of the latest accepted win, scores, winner
   int         edge_n   = 0;
   int         win_edge = -1;
   int         m_s1     = 0;
   int         m_s2     = 0;
   int         m_winner = 0;
   logic [1:0] e_pw = 2'b00;
   logic       e_rr = 1'b0;
   logic       e_mo = 1'b0;
   logic       check_en = 1'b0;

   always #5 clk = ~clk;

   match_referee #(
      .HOLD_CYCLES (HOLD),
      .WIN_SCORE   (WIN),
      .FLASH_HALF  (FH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .p1_win        (p1_win),
      .p2_win        (p2_win),
      .playerWin     (playerWin),
      .round_restart (round_restart),
      .p1_score      (p1_score),
      .p2_score      (p2_score),
      .match_over    (match_over)
   );

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_final();
      if (m_winner == 1) return (m_s1 == WIN);
      else if (m_winner == 2) return (m_s2 == WIN);
      else return 1'b0;
   endfunction

   // Advance the model by one clock edge with the inputs seen at that edge
   task automatic model_step(input logic a, input logic b, input logic r);
      int d;
      bit ready;
      logic [1:0] code;
      if (!r) begin
         win_edge = -1; m_s1 = 0; m_s2 = 0; m_winner = 0;
      end else begin
         // Accept a win only in play: never after match end, and only once
         // show (HOLD) + restart (1) + first play edge have elapsed
         ready = (win_edge < 0) || (!is_final() && (edge_n >= win_edge + HOLD + 2));
         if (ready && (a != b)) begin
            win_edge = edge_n;
            m_winner = a ? 1 : 2;
            if (a) m_s1++; else m_s2++;
         end
      end
      e_pw = 2'b00; e_rr = 1'b0; e_mo = 1'b0;
      if (win_edge >= 0) begin
         d    = edge_n - win_edge;
         code = (m_winner == 1) ? 2'b01 : 2'b10;
         if (d < HOLD) begin
            e_pw = code;
         end else if (is_final()) begin
            e_mo = 1'b1;
`ifdef MATCH_REFEREE_FLASH_EN
            e_pw = ((((d - HOLD) / FH) % 2) == 0) ? code : 2'b00;
`else
            e_pw = code;
`endif
         end else if (d == HOLD) begin
            e_rr = 1'b1;
         end
      end
      edge_n++;
   endtask

   // Cycle-by-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      if (check_en) begin
         chk("playerWin", {2'b00, playerWin}, {2'b00, e_pw});
         chk("round_restart", {3'b000, round_restart}, {3'b000, e_rr});
         chk("match_over", {3'b000, match_over}, {3'b000, e_mo});
         chk("p1_score", p1_score, 4'(m_s1));
         chk("p2_score", p2_score, 4'(m_s2));
      end
   end

   task automatic cyc(input logic a, input logic b, input logic r);
      @(negedge clk);
      p1_win = a; p2_win = b; reset = r;
      @(posedge clk);
      model_step(a, b, r);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      check_en = 1'b1;
      // 1. reset
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      idle(1);
      chk("rst_pw", {2'b00, playerWin}, 4'h0);
      chk("rst_p1", p1_score, 4'h0);
      chk("rst_p2", p2_score, 4'h0);
      chk("rst_mo", {3'b000, match_over}, 4'h0);

      // 2. single P1 round
      cyc(1'b1, 1'b0, 1'b1);
      chk("r1_pw_k1", {2'b00, playerWin}, 4'h1);
      chk("r1_p1_k1", p1_score, 4'h1);
      idle(3);
      chk("r1_pw_k4", {2'b00, playerWin}, 4'h1);
      idle(1);
      chk("r1_rr_k5", {3'b000, round_restart}, 4'h1);
      chk("r1_pw_k5", {2'b00, playerWin}, 4'h0);
      idle(1);
      chk("r1_rr_k6", {3'b000, round_restart}, 4'h0);

      // 3. double pulse ignored, P2 during SHOW ignored
      cyc(1'b1, 1'b1, 1'b1);
      chk("dbl_pw", {2'b00, playerWin}, 4'h0);
      chk("dbl_p1", p1_score, 4'h1);
      chk("dbl_p2", p2_score, 4'h0);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      chk("show_p2", p2_score, 4'h0);
      chk("show_p1", p1_score, 4'h2);
      idle(5);

      // 4. P2 P1 P2 P2 -> match to P2
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1); idle(HOLD + 1);
      cyc(1'b1, 1'b0, 1'b1); idle(HOLD + 1);
      cyc(1'b0, 1'b1, 1'b1); idle(HOLD + 1);
      cyc(1'b0, 1'b1, 1'b1);
      chk("m_p2_3", p2_score, 4'h3);
      idle(HOLD);
      chk("m_over", {3'b000, match_over}, 4'h1);
      chk("m_pw", {2'b00, playerWin}, 4'h2);
      chk("m_rr", {3'b000, round_restart}, 4'h0);
      cyc(1'b1, 1'b0, 1'b1);
      chk("m_frz_p1", p1_score, 4'h1);
      chk("m_frz_p2", p2_score, 4'h3);
`ifdef MATCH_REFEREE_FLASH_EN
      chk("m_flash1", {2'b00, playerWin}, 4'h2);
      idle(1);
      chk("m_flash2", {2'b00, playerWin}, 4'h0);
`else
      idle(1);
      chk("m_steady", {2'b00, playerWin}, 4'h2);
`endif
      idle(6);

      // 5. reset in SHOW and in OVER
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      idle(1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rs_show_pw", {2'b00, playerWin}, 4'h0);
      chk("rs_show_p1", p1_score, 4'h0);
      for (int i = 0; i < WIN; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         idle(HOLD + 1);
      end
      chk("pre_over", {3'b000, match_over}, 4'h1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rs_over_mo", {3'b000, match_over}, 4'h0);
      chk("rs_over_p1", p1_score, 4'h0);

      // 6. randomized play
      for (int i = 0; i < 3000; i++) begin
         int x;
         logic r;
         x = $urandom_range(0, 9);
         r = ($urandom_range(0, 299) != 0);
         cyc((x == 0) || (x == 2), (x == 1) || (x == 2), r);
      end

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/match_referee.md
Name: match_referee

Overview:
- Sequential referee for the two-player tug-of-war game.
- Takes single-cycle round-win pulses from the playfield logic and latches the round winner.
- Drives the 2-bit winner code consumed by the hex display decoder, holds it for a fixed display time, then restarts the playfield.
- Keeps per-player scores and ends the match when one player reaches WIN_SCORE.

Parameters:
- HOLD_CYCLES, 16: cycles the round winner is shown before restart; must be >= 1.
- WIN_SCORE, 3: rounds needed to win the match; range 1..15.
- FLASH_HALF, 8: half-period in cycles of the winner flash in OVER; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a clk edge resets the block.
- p1_win  in  1  one-cycle pulse: player 1 took the current round.
- p2_win  in  1  one-cycle pulse: player 2 took the current round.
- playerWin  out  2  winner code to the display decoder: 2'b00 none, 2'b01 P1, 2'b10 P2; never 2'b11.
- round_restart  out  1  one-cycle pulse that clears and re-centres the playfield.
- p1_score  out  4  player 1 rounds won, unsigned.
- p2_score  out  4  player 2 rounds won, unsigned.
- match_over  out  1  high while in state OVER.

Behaviour:
- All outputs are registered.
- Reset values: state=PLAY, playerWin=00, round_restart=0, scores=0, match_over=0, hold counter=0.
- A reset asserted in any state, including mid-SHOW or OVER, takes effect at that edge and overrides all other inputs.

State PLAY:
- Exactly one of p1_win/p2_win high at edge k: at edge k the state goes to SHOW, playerWin gets that player's code, that player's score increments, and the hold counter clears.
- Outputs are visible in cycle k+1, so latency from the pulse is 1 cycle.
- Both pulses high in the same cycle: treated as no event; stay in PLAY, nothing changes.

State SHOW:
- The hold counter increments every cycle. Win pulses are ignored.
- When counter==HOLD_CYCLES-1: go to OVER if the winner's score==WIN_SCORE, otherwise go to RESTART.
- SHOW therefore lasts exactly HOLD_CYCLES cycles.

State RESTART:
- Lasts exactly 1 cycle, with round_restart=1 and playerWin=00. Win pulses are ignored.
- Next state is PLAY, with round_restart=0.

State OVER:
- match_over=1 and playerWin holds the match winner's code.
- Win pulses are ignored and scores are frozen. Only reset exits OVER.

Scores:
- Scores are 4-bit and never exceed WIN_SCORE, so no wrap-around is possible.
- Scores are never decremented except by reset.

Optional Feature:
- Macro: MATCH_REFEREE_FLASH_EN.
- Defined: in OVER, playerWin alternates between the winner code and 00 every FLASH_HALF cycles. It starts with the winner code in the first OVER cycle, driven by a free-running flash counter that clears on OVER entry.
- Undefined: playerWin is steady in OVER, no flash counter exists, and FLASH_HALF is unused.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package match_referee_pkg holds:
  - typedef enum logic [1:0] {PLAY, SHOW, RESTART, OVER} ref_state_t;
  - constants PW_NONE=2'b00, PW_P1=2'b01, PW_P2=2'b10;
  - SCORE_W=4.
- Sub-module term_counter (parameter N; inputs clk, reset, clr, en; output done high when count==N-1; width $clog2(N)+1).
- term_counter is instantiated once for the SHOW hold, and once more for the flash when MATCH_REFEREE_FLASH_EN is defined.

Test Plan:
All scenarios use HOLD_CYCLES=4 and WIN_SCORE=3.
1. Reset low 2 cycles, then high -> playerWin=00, scores 0/0, round_restart=0, match_over=0.
2. p1_win pulse at edge k -> cycles k+1..k+4: playerWin=01, p1_score=1. Cycle k+5: round_restart=1, playerWin=00. Cycle k+6: round_restart=0, state PLAY.
3. p1_win and p2_win high in the same cycle in PLAY -> no change to scores, playerWin or state. p2_win during SHOW -> ignored, p2_score unchanged.
4. Alternating wins P2, P1, P2, P2 -> p2_score reaches 3 after the 4th round. After its 4 SHOW cycles: match_over=1, playerWin=10, no round_restart pulse. A further p1_win -> scores stay 1/3.
5. Reset low during cycle 2 of SHOW -> next cycle all outputs at reset values. Reset low in OVER -> match_over=0, scores=0.
6. With MATCH_REFEREE_FLASH_EN and FLASH_HALF=2, in OVER -> playerWin sequence 10,10,00,00,10,10... Without the macro -> steady 10.
